// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, issues single-outstanding imem requests and
// hands a registered instruction to decode over a valid/ready handshake.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic [1:0]  npc_op,
  input  logic        br_taken,
  input  logic [31:0] imm,
  input  logic [31:0] alu_c,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_VALID,
    S_HALT
  } state_t;

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q;
  logic [31:0]   pc_q;
  logic [31:0]   inst_q;
  logic [31:0]   inst_pc_q;
  logic          valid_q;
  logic          req_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   npc;
  logic [31:0]   pc_plus4;
  logic [31:0]   pc_plus_imm;

  assign pc_plus4    = inst_pc_q + 32'd4;
  assign pc_plus_imm = inst_pc_q + imm;

  always_comb begin
    npc = pc_plus4;
    case (npc_op)
      2'b00: npc = pc_plus4;
      2'b01: npc = alu_c & 32'hFFFF_FFFE;
      2'b10: npc = br_taken ? pc_plus_imm : pc_plus4;
      2'b11: npc = pc_plus_imm;
      default: npc = pc_plus4;
    endcase
  end

  // req_q is cleared by reset, so the first FETCH cycle after release only
  // raises the request; a grant is honoured only while the request is up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      inst_q    <= 32'h0000_0013;
      inst_pc_q <= RESET_PC;
      valid_q   <= 1'b0;
      req_q     <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          req_q <= 1'b1;
          if (req_q && imem_gnt) begin
            req_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            inst_q    <= imem_rdata;
            inst_pc_q <= pc_q;
            valid_q   <= 1'b1;
            state_q   <= S_VALID;
          end else if (cnt_q == CNT_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_HALT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_VALID: begin
          if (inst_ready) begin
            pc_q    <= npc;
            valid_q <= 1'b0;
            if (npc[1:0] == 2'b00) begin
              req_q   <= 1'b1;
              state_q <= S_FETCH;
            end else begin
              err_q   <= 1'b1;
              state_q <= S_HALT;
            end
          end
        end
        S_HALT: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_pc4   = pc_plus4;
  assign inst_valid = valid_q;
  assign fetch_err  = err_q;

endmodule
